// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial 16-bit ALU.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - operation-select constants for s and mode constants for m
//   - nibble width and nibble count
//   - modify_b(): operand-B modifier used by the arithmetic path and by the
//     overflow flag (so both agree on what "effective B" means)
package alu_pkg;

  localparam int NIB_W = 4;
  localparam int NIB_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Mode select
  localparam logic M_ARITH = 1'b0;
  localparam logic M_LOGIC = 1'b1;

  // Arithmetic ops (m = 0)
  localparam logic [1:0] S_ADD   = 2'b00;  // A + B + ci
  localparam logic [1:0] S_INC   = 2'b01;  // A + ci
  localparam logic [1:0] S_SUB   = 2'b10;  // A + ~B + ci
  localparam logic [1:0] S_DEC   = 2'b11;  // A + 0xFFFF + ci

  // Logic ops (m = 1)
  localparam logic [1:0] S_AND   = 2'b00;
  localparam logic [1:0] S_OR    = 2'b01;
  localparam logic [1:0] S_XOR   = 2'b10;
  localparam logic [1:0] S_NOTA  = 2'b11;

  // Effective B nibble seen by the adder for a given arithmetic op.
  function automatic logic [NIB_W-1:0] modify_b(input logic [NIB_W-1:0] b4,
                                                 input logic [1:0]       s);
    logic [NIB_W-1:0] r;
    case (s)
      S_ADD:   r = b4;
      S_INC:   r = '0;
      S_SUB:   r = ~b4;
      default: r = '1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_nibble_slice.sv
// Combinational 4-bit ALU slice: operand modify, add, and logic ops.
// Ports:
//   a4, b4 : in  4  operand nibbles
//   s      : in  2  operation select
//   m      : in  1  mode (0 arithmetic, 1 logic)
//   cin    : in  1  carry in (arithmetic only)
//   f4     : out 4  result nibble
//   cout   : out 1  carry out (0 in logic mode)
module alu_nibble_slice
  import alu_pkg::*;
(
  input  logic [NIB_W-1:0] a4,
  input  logic [NIB_W-1:0] b4,
  input  logic [1:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic [NIB_W-1:0] f4,
  output logic             cout
);

  logic [NIB_W:0] sum;

  always_comb begin
    sum  = {1'b0, a4} + {1'b0, modify_b(b4, s)} + {{NIB_W{1'b0}}, cin};
    f4   = '0;
    cout = 1'b0;
    if (m == M_ARITH) begin
      f4   = sum[NIB_W-1:0];
      cout = sum[NIB_W];
    end else begin
      case (s)
        S_AND:   f4 = a4 & b4;
        S_OR:    f4 = a4 | b4;
        S_XOR:   f4 = a4 ^ b4;
        default: f4 = ~a4;
      endcase
    end
  end

endmodule

// File: rtl/nibble_serial_alu16.sv
// 16-bit ALU that processes one nibble per clock, LSB nibble first, with the
// carry chained between nibbles through a single flop.
// Ports:
//   clk   : in  1   rising-edge clock
//   rst   : in  1   synchronous active-high reset (aborts any operation)
//   start : in  1   request, sampled only in IDLE
//   a, b  : in  16  operands, captured on accepted start
//   s     : in  2   operation select
//   m     : in  1   mode, 0 arithmetic / 1 logic
//   ci    : in  1   carry in
//   busy  : out 1   high while in RUN
//   done  : out 1   one-cycle completion pulse (DONE state)
//   f     : out 16  result
//   co    : out 1   carry out of nibble 3 (arithmetic only)
//   zero  : out 1   f == 0
//   ovf   : out 1   signed overflow (arithmetic only)
module nibble_serial_alu16
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [1:0]  s,
  input  logic        m,
  input  logic        ci,
  output logic        busy,
  output logic        done,
  output logic [15:0] f,
  output logic        co,
  output logic        zero,
  output logic        ovf
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [1:0]  s_q, s_d;
  logic        m_q, m_d;
  logic [15:0] f_q, f_d;
  logic        co_q, co_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;

  // Captured operands split into nibbles so the slice can be fed by index.
  logic [NIB_W-1:0] a_nib [NIB_N];
  logic [NIB_W-1:0] b_nib [NIB_N];

  genvar gi;
  generate
    for (gi = 0; gi < NIB_N; gi++) begin : g_nib
      assign a_nib[gi] = a_q[gi*NIB_W +: NIB_W];
      assign b_nib[gi] = b_q[gi*NIB_W +: NIB_W];
    end
  endgenerate

  logic [NIB_W-1:0] slice_f;
  logic             slice_co;

  alu_nibble_slice u_slice (
    .a4   (a_nib[idx_q]),
    .b4   (b_nib[idx_q]),
    .s    (s_q),
    .m    (m_q),
    .cin  (carry_q),
    .f4   (slice_f),
    .cout (slice_co)
  );

  // Top-nibble effective B, needed for the signed-overflow rule.
  logic [NIB_W-1:0] b_top_eff;
  logic [15:0]      f_full;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    m_d       = m_q;
    f_d       = f_q;
    co_d      = co_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    b_top_eff = modify_b(b_q[15:12], s_q);
    f_full    = {slice_f, f_q[11:0]};

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          idx_d   = 2'd0;
          // Logic mode never propagates carry, so the chain starts at 0.
          carry_d = (m == M_ARITH) ? ci : 1'b0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        f_d[{idx_q, 2'b00} +: NIB_W] = slice_f;
        carry_d = slice_co;
        idx_d   = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          // Flags are settled on the same edge the last nibble lands.
          state_d = ST_DONE;
          zero_d  = (f_full == 16'h0000);
          co_d    = (m_q == M_ARITH) ? slice_co : 1'b0;
          ovf_d   = (m_q == M_ARITH) && (b_top_eff[3] == a_q[15]) &&
                    (slice_f[3] != a_q[15]);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      f_q     <= '0;
      co_q    <= 1'b0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      f_q     <= f_d;
      co_q    <= co_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign f    = f_q;
  assign co   = co_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/nibble_serial_alu16.md
NIBBLE_SERIAL_ALU16 -- requirements
Module: nibble_serial_alu16

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk and rst are the only timing inputs.
REQ-002 SHALL expose ports: clk  in  1  rising-edge clock.
REQ-003 SHALL expose: rst  in  1  synchronous active-high reset.
REQ-004 SHALL expose: start  in  1  request; sampled only in IDLE.
REQ-005 SHALL expose: a, b  in  16 each  operands, captured when start is accepted.
REQ-006 SHALL expose: s  in  2  operation select, captured with operands.
REQ-007 SHALL expose: m  in  1  mode; 0 = arithmetic, 1 = logic; captured with operands.
REQ-008 SHALL expose: ci  in  1  carry-in, captured with operands.
REQ-009 SHALL expose: busy  out  1  high while in RUN.
REQ-010 SHALL expose: done  out  1  one-cycle completion pulse.
REQ-011 SHALL expose: f  out  16  result.
REQ-012 SHALL expose: co, zero, ovf  out  1 each  carry-out, f==0, signed overflow.

Function
REQ-013 SHALL use an FSM with states IDLE, RUN and DONE.
REQ-014 SHALL, in IDLE with start=1, on that edge latch a, b, s, m and ci, clear the nibble index to 0, load the carry flop with ci when m=0 and with 0 when m=1, and enter RUN.
REQ-015 SHALL, in RUN, process one nibble per edge, LSB nibble first, in the order index 0,1,2,3; nibble k writes f[4k+3:4k] and updates the carry flop.
REQ-016 SHALL leave RUN for DONE on the edge that processes index 3; DONE returns to IDLE after exactly one cycle.
REQ-017 SHALL drive done=1 only in DONE, i.e. 4 edges after the edge that accepted start; busy=1 only in RUN (4 cycles).
REQ-018 SHALL ignore start while in RUN or DONE; there is no queueing.
REQ-019 SHALL select the arithmetic operation (m=0) by s as follows: 00 = A+B+ci; 01 = A+ci (B forced to 0); 10 = A+~B+ci (ci=1 gives A−B); 11 = A+0xFFFF+ci (ci=0 gives A−1).
REQ-020 SHALL select the logic operation (m=1) by s as follows: 00 = A&B; 01 = A|B; 10 = A^B; 11 = ~A; the nibble carry is held at 0.
REQ-021 SHALL chain the nibble carry through the carry flop only, with no combinational carry across nibbles.
REQ-022 SHALL register co in DONE as the carry out of nibble 3 when m=0; co=0 when m=1.
REQ-023 SHALL set ovf=1 when m=0 and the effective-B[15] equals A[15] and f[15] differs from A[15]; ovf=0 when m=1.
REQ-024 SHALL set zero=(f==16'h0000).
REQ-025 SHALL hold f, co, zero and ovf stable from DONE until the next accepted start; a partial f SHALL NOT be exposed as valid while busy=1.
REQ-026 SHALL wrap 16-bit arithmetic modulo 2^16, with the overflow bit reported only through co.

Reset
REQ-027 SHALL, when rst=1 at an edge, force state to IDLE, the nibble index to 0, the carry flop to 0, f to 0, co, ovf, busy and done to 0, and zero to 1.
REQ-028 SHALL treat rst=1 during RUN or DONE as an abort: no done pulse is produced for the aborted operation.
REQ-029 SHALL give rst precedence over start on the same edge.

Structure
REQ-030 SHALL place the state encoding (IDLE/RUN/DONE), the op-select constants for s and m, and the nibble width and count (4, 4) in a shared package, alu_pkg.
REQ-031 SHALL implement the 4-bit operand-modify/add/logic datapath as one combinational sub-module, alu_nibble_slice, with inputs a4, b4, s, m, cin and outputs f4, cout.
REQ-032 SHALL keep sequencing, capture registers and flag generation in nibble_serial_alu16.

Verification
REQ-033 SHALL cover an add with carry ripple: a=0x00FF, b=0x0001, s=00, m=0, ci=0 -> f=0x0100, co=0, zero=0, ovf=0, with done exactly 4 edges after start.
REQ-034 SHALL cover a subtract with borrow: a=0x0000, b=0x0001, s=10, m=0, ci=1 -> f=0xFFFF, co=0; and a=0x0005, b=0x0005 -> f=0x0000, co=1, zero=1.
REQ-035 SHALL cover signed overflow: a=0x7FFF, b=0x0001, s=00, m=0, ci=0 -> f=0x8000, ovf=1, co=0.
REQ-036 SHALL cover logic ops: a=0xF0F0, b=0xFF00, m=1 -> s=00 gives 0xF000, 01 gives 0xFFF0, 10 gives 0x0FF0, 11 gives 0x0F0F; co=0 and ovf=0 in every case.
REQ-037 SHALL cover a start pulse during RUN with different operands: it is ignored, the original result completes, and exactly one done pulse is produced.
REQ-038 SHALL cover rst asserted on the second RUN cycle: the next cycle is IDLE with all outputs at reset values and no done pulse; a subsequent start completes normally.
